// File: rtl/usb_buf_pkg.sv
// Shared constants and per-endpoint bookkeeping for the ping-pong IN-endpoint buffer.
package usb_buf_pkg;

  localparam int unsigned NumEpDefault = 4;
  localparam int unsigned AddrWDefault = 9;
  // Stored lengths are kept at a fixed width; the top narrows them to ADDR_W+1 bits.
  localparam int unsigned LenMaxW      = 16;

  typedef struct packed {
    logic                    wr_bank;
    logic                    rd_bank;
    logic [1:0]              full_cnt;
    logic [1:0][LenMaxW-1:0] len;
    logic                    toggle;
  } ep_state_t;

endpackage

// File: rtl/usb_ep_buf_ram.sv
// Simple dual-port byte RAM: one write port, one registered read port.
module usb_ep_buf_ram #(
  parameter int unsigned Words = 4096,
  parameter int unsigned AW    = 12
) (
  input  logic          phy_ulpi_clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [7:0]    wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_q
);

  logic [7:0] mem [Words];

  always_ff @(posedge phy_ulpi_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Separate process so a same-edge write is not visible to the read (old data returned).
  always_ff @(posedge phy_ulpi_clk) begin
    if (reset) begin
      rd_q <= '0;
    end else begin
      rd_q <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/usb_ep_in_buf.sv
// Multi-endpoint double-buffered IN buffer: application fills and commits banks,
// the protocol engine reads the oldest committed bank and releases it on handshake.
module usb_ep_in_buf
  import usb_buf_pkg::*;
#(
  parameter int unsigned NUM_EP = NumEpDefault,
  parameter int unsigned ADDR_W = AddrWDefault,
  parameter int unsigned EP_W   = (NUM_EP > 1) ? $clog2(NUM_EP) : 1
) (
  input  logic              phy_ulpi_clk,
  input  logic              reset,
  input  logic [EP_W-1:0]   app_ep,
  input  logic [ADDR_W-1:0] app_addr,
  input  logic [7:0]        app_data,
  input  logic              app_wren,
  input  logic              app_commit,
  input  logic [ADDR_W:0]   app_commit_len,
  output logic              app_commit_ack,
  output logic              app_commit_err,
  output logic [NUM_EP-1:0] app_ready,
  input  logic [EP_W-1:0]   usb_ep,
  input  logic [ADDR_W-1:0] usb_rd_addr,
  output logic [7:0]        usb_rd_q,
  output logic [ADDR_W:0]   usb_len,
  output logic [NUM_EP-1:0] usb_hasdata,
  output logic [NUM_EP-1:0] usb_data1,
  input  logic              usb_done,
  input  logic [NUM_EP-1:0] ep_flush,
  input  logic [NUM_EP-1:0] ep_clr_toggle
);

  localparam int unsigned DEPTH    = 2 ** ADDR_W;
  localparam int unsigned RAM_AW   = EP_W + 1 + ADDR_W;
  localparam logic [ADDR_W:0] DepthLen = (ADDR_W + 1)'(DEPTH);

  ep_state_t st_q [NUM_EP];
  ep_state_t st_d [NUM_EP];
  logic ack_q, err_q;
  logic ack_d, err_d;

  logic [NUM_EP-1:0]  ep_ready, commit_hit, done_hit;
  logic               wr_en, wr_bank_sel, rd_bank_sel;
  logic [LenMaxW-1:0] sel_len;
  logic [ADDR_W:0]    clip_len;
  logic               unused_len;

  assign clip_len = (app_commit_len > DepthLen) ? DepthLen : app_commit_len;

  always_comb begin
    for (int unsigned e = 0; e < NUM_EP; e++) begin
      ep_ready[e]    = st_q[e].full_cnt != 2'd2;
      usb_hasdata[e] = st_q[e].full_cnt != 2'd0;
      usb_data1[e]   = st_q[e].toggle;
    end
  end

  always_comb begin
    commit_hit  = '0;
    done_hit    = '0;
    wr_en       = 1'b0;
    wr_bank_sel = 1'b0;
    rd_bank_sel = 1'b0;
    sel_len     = '0;
    for (int unsigned e = 0; e < NUM_EP; e++) begin
      if (EP_W'(e) == app_ep) begin
        wr_en         = app_wren & ep_ready[e];
        wr_bank_sel   = st_q[e].wr_bank;
        commit_hit[e] = app_commit & ep_ready[e] & ~ep_flush[e];
      end
      if (EP_W'(e) == usb_ep) begin
        rd_bank_sel = st_q[e].rd_bank;
        sel_len     = st_q[e].len[st_q[e].rd_bank];
        // A flush on the same endpoint swallows the release entirely.
        done_hit[e] = usb_done & (st_q[e].full_cnt != 2'd0) & ~ep_flush[e];
      end
    end
  end

  always_comb begin
    for (int unsigned e = 0; e < NUM_EP; e++) begin
      st_d[e] = st_q[e];
      if (commit_hit[e]) begin
        st_d[e].len[st_q[e].wr_bank] = LenMaxW'(clip_len);
        st_d[e].wr_bank              = ~st_q[e].wr_bank;
      end
      if (done_hit[e]) begin
        st_d[e].rd_bank = ~st_q[e].rd_bank;
        st_d[e].toggle  = ~st_q[e].toggle;
      end
      if (commit_hit[e] && !done_hit[e]) begin
        st_d[e].full_cnt = st_q[e].full_cnt + 2'd1;
      end else if (done_hit[e] && !commit_hit[e]) begin
        st_d[e].full_cnt = st_q[e].full_cnt - 2'd1;
      end
      if (ep_clr_toggle[e]) begin
        st_d[e].toggle = 1'b0;
      end
      if (ep_flush[e]) begin
        st_d[e].full_cnt = 2'd0;
        st_d[e].wr_bank  = 1'b0;
        st_d[e].rd_bank  = 1'b0;
      end
    end
  end

  assign ack_d = |commit_hit;
  // Oversized commits are accepted (clipped) but still flagged.
  assign err_d = app_commit & (~(|commit_hit) | (app_commit_len > DepthLen));

  always_ff @(posedge phy_ulpi_clk) begin
    if (reset) begin
      for (int unsigned e = 0; e < NUM_EP; e++) begin
        st_q[e] <= '0;
      end
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      for (int unsigned e = 0; e < NUM_EP; e++) begin
        st_q[e] <= st_d[e];
      end
      ack_q <= ack_d;
      err_q <= err_d;
    end
  end

  assign app_ready      = ep_ready;
  assign app_commit_ack = ack_q;
  assign app_commit_err = err_q;
  assign usb_len        = sel_len[ADDR_W:0];
  assign unused_len     = ^sel_len[LenMaxW-1:ADDR_W+1];

  usb_ep_buf_ram #(
    .Words (NUM_EP * 2 * DEPTH),
    .AW    (RAM_AW)
  ) u_ram (
    .phy_ulpi_clk (phy_ulpi_clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      ({app_ep, wr_bank_sel, app_addr}),
    .wr_data      (app_data),
    .rd_addr      ({usb_ep, rd_bank_sel, usb_rd_addr}),
    .rd_q         (usb_rd_q)
  );

endmodule

// File: tb/tb_usb_ep_in_buf.sv
// Scoreboard bench for usb_ep_in_buf: a queue-based endpoint model predicts commit
// responses, read data and per-endpoint status; a negedge monitor compares.
module tb_usb_ep_in_buf;

  localparam int NE    = 4;
  localparam int AW    = 9;
  localparam int DEPTH = 512;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    app_ep;
  logic [AW-1:0] app_addr;
  logic [7:0]    app_data;
  logic          app_wren, app_commit;
  logic [AW:0]   app_commit_len;
  logic          app_commit_ack, app_commit_err;
  logic [NE-1:0] app_ready;
  logic [1:0]    usb_ep;
  logic [AW-1:0] usb_rd_addr;
  logic [7:0]    usb_rd_q;
  logic [AW:0]   usb_len;
  logic [NE-1:0] usb_hasdata, usb_data1;
  logic          usb_done;
  logic [NE-1:0] ep_flush, ep_clr_toggle;

  usb_ep_in_buf dut (
    .phy_ulpi_clk   (clk),
    .reset          (reset),
    .app_ep         (app_ep),
    .app_addr       (app_addr),
    .app_data       (app_data),
    .app_wren       (app_wren),
    .app_commit     (app_commit),
    .app_commit_len (app_commit_len),
    .app_commit_ack (app_commit_ack),
    .app_commit_err (app_commit_err),
    .app_ready      (app_ready),
    .usb_ep         (usb_ep),
    .usb_rd_addr    (usb_rd_addr),
    .usb_rd_q       (usb_rd_q),
    .usb_len        (usb_len),
    .usb_hasdata    (usb_hasdata),
    .usb_data1      (usb_data1),
    .usb_done       (usb_done),
    .ep_flush       (ep_flush),
    .ep_clr_toggle  (ep_clr_toggle)
  );

  always #5 clk = ~clk;

  // Reference model: committed banks are a FIFO of lengths; bank index is the number of
  // commits (write side) or releases (read side) since the last flush, modulo two.
  typedef struct { int unsigned cyc; logic [1:0] ae; } aexp_t;
  typedef struct { int unsigned cyc; logic [7:0] d; } rexp_t;
  int          lens [NE][$];
  int          ncom [NE];
  int          ndone[NE];
  bit          tog  [NE];
  logic [7:0]  mem  [NE][2][DEPTH];
  bit          wrt  [NE][2][DEPTH];
  aexp_t       aq[$];
  rexp_t       rq[$];
  int unsigned cyc = 0;
  int          checks = 0;
  int          failures = 0;
  bit          rd_chk, started = 0;

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endfunction

  task automatic model_edge();
    int ae, ue, wb, rb;
    bit acc, dn, clip;
    aexp_t a;
    rexp_t r;
    if (reset) begin
      for (int e = 0; e < NE; e++) begin
        lens[e].delete();
        ncom[e] = 0;
        ndone[e] = 0;
        tog[e] = 0;
      end
      aq.delete();
      rq.delete();
      return;
    end
    ae = int'(app_ep);
    ue = int'(usb_ep);
    wb = ncom[ae] % 2;
    rb = ndone[ue] % 2;
    // Expected read data is taken before this edge's write: old data on collision.
    if (rd_chk && wrt[ue][rb][usb_rd_addr]) begin
      r.cyc = cyc + 1;
      r.d = mem[ue][rb][usb_rd_addr];
      rq.push_back(r);
    end
    if (app_wren && lens[ae].size() < 2) begin
      mem[ae][wb][app_addr] = app_data;
      wrt[ae][wb][app_addr] = 1;
    end
    acc = 0;
    clip = int'(app_commit_len) > DEPTH;
    if (app_commit) begin
      acc = lens[ae].size() < 2 && !ep_flush[ae];
      a.cyc = cyc + 1;
      a.ae = {acc, !acc || clip};
      aq.push_back(a);
    end
    dn = usb_done && lens[ue].size() > 0 && !ep_flush[ue];
    if (dn) begin
      void'(lens[ue].pop_front());
      ndone[ue]++;
      tog[ue] = !tog[ue];
    end
    if (acc) begin
      lens[ae].push_back(clip ? DEPTH : int'(app_commit_len));
      ncom[ae]++;
    end
    for (int e = 0; e < NE; e++) begin
      if (ep_clr_toggle[e]) tog[e] = 0;
      if (ep_flush[e]) begin
        lens[e].delete();
        ncom[e] = 0;
        ndone[e] = 0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (started && !reset) begin
      logic [NE-1:0] er, eh, ed;
      int ue;
      for (int e = 0; e < NE; e++) begin
        er[e] = lens[e].size() < 2;
        eh[e] = lens[e].size() > 0;
        ed[e] = tog[e];
      end
      chk("app_ready", 32'(app_ready), 32'(er));
      chk("usb_hasdata", 32'(usb_hasdata), 32'(eh));
      chk("usb_data1", 32'(usb_data1), 32'(ed));
      ue = int'(usb_ep);
      if (lens[ue].size() > 0) chk("usb_len", 32'(usb_len), 32'(lens[ue][0]));
      if (app_commit_ack || app_commit_err) begin
        if (aq.size() == 0) begin
          chk("spurious_ack_err", 32'({app_commit_ack, app_commit_err}), 32'(0));
        end else begin
          aexp_t a;
          a = aq.pop_front();
          chk("ack_err", 32'({app_commit_ack, app_commit_err}), 32'(a.ae));
          chk("ack_err_cycle", cyc, a.cyc);
        end
      end else if (aq.size() > 0 && aq[0].cyc <= cyc) begin
        aexp_t a;
        a = aq.pop_front();
        chk("missing_ack_err", 32'(0), 32'(a.ae));
      end
      if (rq.size() > 0 && rq[0].cyc == cyc) begin
        rexp_t r;
        r = rq.pop_front();
        chk("usb_rd_q", 32'(usb_rd_q), 32'(r.d));
      end
    end
  end

  task automatic clr();
    app_wren = 0;
    app_commit = 0;
    usb_done = 0;
    ep_flush = '0;
    ep_clr_toggle = '0;
    rd_chk = 0;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    cyc++;
    #1;
  endtask

  task automatic commit(input int ep, input int len);
    clr();
    app_ep = 2'(ep);
    app_commit = 1;
    app_commit_len = (AW + 1)'(len);
    step();
    clr();
  endtask

  initial begin
    clr();
    reset = 1;
    app_ep = 0; app_addr = 0; app_data = 0; app_commit_len = 0;
    usb_ep = 0; usb_rd_addr = 0;
    step();
    step();
    reset = 0;
    started = 1;
    @(negedge clk);
    chk("rst_ready", 32'(app_ready), 32'hF);
    chk("rst_hasdata", 32'(usb_hasdata), 32'h0);
    chk("rst_data1", 32'(usb_data1), 32'h0);
    chk("rst_len", 32'(usb_len), 32'h0);
    chk("rst_rd_q", 32'(usb_rd_q), 32'h0);
    chk("rst_ack_err", 32'({app_commit_ack, app_commit_err}), 32'h0);

    // EP1: 64 bytes, commit, read back
    for (int i = 0; i < 64; i++) begin
      clr();
      app_ep = 1; app_addr = AW'(i); app_data = 8'(i); app_wren = 1;
      step();
    end
    commit(1, 64);
    @(negedge clk);
    chk("t1_ack", 32'(app_commit_ack), 32'h1);
    usb_ep = 1; usb_rd_addr = 5; rd_chk = 1;
    step();
    clr();
    @(negedge clk);
    chk("t1_rd_q", 32'(usb_rd_q), 32'h05);
    chk("t1_len", 32'(usb_len), 32'd64);
    chk("t1_hasdata", 32'(usb_hasdata[1]), 32'h1);
    chk("t1_data1", 32'(usb_data1[1]), 32'h0);

    // EP2: third commit with no release is rejected
    commit(2, 3);
    commit(2, 4);
    @(negedge clk);
    chk("t2_ready", 32'(app_ready[2]), 32'h0);
    commit(2, 5);
    @(negedge clk);
    chk("t2_err", 32'({app_commit_ack, app_commit_err}), 32'h1);

    // EP0: two banks drained in order, toggle follows
    commit(0, 10);
    commit(0, 20);
    usb_ep = 0;
    step();
    @(negedge clk);
    chk("t3_len0", 32'(usb_len), 32'd10);
    usb_done = 1;
    step();
    clr();
    @(negedge clk);
    chk("t3_len1", 32'(usb_len), 32'd20);
    chk("t3_tog1", 32'(usb_data1[0]), 32'h1);
    usb_done = 1;
    step();
    clr();
    @(negedge clk);
    chk("t3_tog2", 32'(usb_data1[0]), 32'h0);
    chk("t3_empty", 32'(usb_hasdata[0]), 32'h0);

    // EP3: commit and release in the same cycle
    commit(3, 7);
    app_ep = 3; app_commit = 1; app_commit_len = 33; usb_ep = 3; usb_done = 1;
    step();
    clr();
    @(negedge clk);
    chk("t4_len", 32'(usb_len), 32'd33);
    chk("t4_ready", 32'(app_ready[3]), 32'h1);
    chk("t4_ack", 32'(app_commit_ack), 32'h1);

    // Oversized commit is clipped and flagged
    usb_ep = 0;
    commit(0, 600);
    @(negedge clk);
    chk("t5_ack_err", 32'({app_commit_ack, app_commit_err}), 32'h3);
    chk("t5_len", 32'(usb_len), 32'd512);

    // EP1: release, recommit, then flush racing a commit, then clear toggle
    usb_ep = 1; usb_done = 1;
    step();
    commit(1, 4);
    app_ep = 1; app_commit = 1; app_commit_len = 8; ep_flush = 4'b0010;
    step();
    clr();
    @(negedge clk);
    chk("t6_err", 32'({app_commit_ack, app_commit_err}), 32'h1);
    chk("t6_hasdata", 32'(usb_hasdata[1]), 32'h0);
    chk("t6_tog_kept", 32'(usb_data1[1]), 32'h1);
    ep_clr_toggle = 4'b0010;
    step();
    clr();
    @(negedge clk);
    chk("t6_tog_clr", 32'(usb_data1[1]), 32'h0);

    // Random traffic with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      clr();
      app_ep = 2'($urandom_range(0, 3));
      app_addr = AW'($urandom_range(0, 15));
      app_data = 8'($urandom);
      app_wren = 1'($urandom_range(0, 1));
      app_commit = ($urandom_range(0, 7) == 0);
      app_commit_len = (AW + 1)'($urandom_range(0, 560));
      usb_ep = 2'($urandom_range(0, 3));
      usb_rd_addr = AW'($urandom_range(0, 15));
      usb_done = ($urandom_range(0, 5) == 0);
      rd_chk = 1;
      for (int b = 0; b < NE; b++) begin
        ep_flush[b] = ($urandom_range(0, 63) == 0);
        ep_clr_toggle[b] = ($urandom_range(0, 63) == 0);
      end
      reset = (i == 1500);
      step();
    end
    clr();
    reset = 0;
    step();
    step();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
